// File: rtl/csi2_hdr_arbiter.sv
// Round-robin arbiter and header scheduler sharing one CSI-2 packet-header/D-PHY TX
// path between up to four per-channel header buffers. Enforces a post-packet gap and
// aborts transfers that never report completion.
module csi2_hdr_arbiter #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned MIN_GAP = 2,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic                   tx_clk_i,
    input  logic                   reset_tx_i,
    input  logic                   enable_i,
    input  logic [NUM_CH-1:0]      ch_mask_i,
    input  logic [NUM_CH-1:0]      hdr_req_i,
    input  logic [16*NUM_CH-1:0]   hdr_wdcnt_i,
    input  logic [6*NUM_CH-1:0]    hdr_dtype_i,
    input  logic [NUM_CH-1:0]      hdr_sptype_i,
    input  logic [NUM_CH-1:0]      hdr_xfrdone_i,
    input  logic                   c2d_hs_rdy_i,
    output logic                   arb_rdy_o,
    output logic [NUM_CH-1:0]      arb_gnt_o,
    output logic                   pkt_req_o,
    output logic [15:0]            pkt_wdcnt_o,
    output logic [5:0]             pkt_dtype_o,
    output logic [1:0]             pkt_vc_o,
    output logic                   pkt_sp_o,
    output logic                   busy_o,
    output logic                   err_timeout_o
);

    typedef enum logic [1:0] {
        StIdle,
        StXfer,
        StGap
    } state_e;

    localparam bit          WD_EN    = (TIMEOUT > 0);
    localparam bit          GAP_EN   = (MIN_GAP > 0);
    localparam logic [15:0] WD_LAST  = WD_EN ? 16'(TIMEOUT - 1) : 16'd0;
    localparam logic [7:0]  GAP_LOAD = GAP_EN ? 8'(MIN_GAP - 1) : 8'd0;

    state_e              r_state;
    state_e              w_state_nxt;
    logic [1:0]          r_rr_ptr;
    logic [15:0]         r_wd_cnt;
    logic [7:0]          r_gap_cnt;

    logic [NUM_CH-1:0]   r_gnt;
    logic                r_pkt_req;
    logic [15:0]         r_pkt_wdcnt;
    logic [5:0]          r_pkt_dtype;
    logic [1:0]          r_pkt_vc;
    logic                r_pkt_sp;
    logic                r_rdy;
    logic                r_err;

    logic [NUM_CH-1:0]   w_elig;
    logic [2:0]          w_scan;
    logic [1:0]          w_sel_idx;
    logic                w_sel_vld;
    logic [NUM_CH-1:0]   w_sel_oh;
    logic                w_done;
    logic                w_wd_hit;
    logic                w_start;
    logic                w_release;
    logic                w_timeout;
    logic [2:0]          w_vc_inc;
    logic [1:0]          w_rr_nxt;

    assign w_elig   = hdr_req_i & ch_mask_i;
    // Only the granted channel's completion pulse counts.
    assign w_done   = |(hdr_xfrdone_i & r_gnt);
    assign w_wd_hit = WD_EN && (r_wd_cnt == WD_LAST);
    assign w_vc_inc = 3'(r_pkt_vc) + 3'd1;
    assign w_rr_nxt = (w_vc_inc >= 3'(NUM_CH)) ? 2'd0 : w_vc_inc[1:0];

    // Pick the first eligible channel at or above rr_ptr, wrapping modulo NUM_CH.
    always_comb begin
        w_scan    = '0;
        w_sel_idx = '0;
        w_sel_vld = 1'b0;
        w_sel_oh  = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            w_scan = 3'(r_rr_ptr) + 3'(i);
            if (w_scan >= 3'(NUM_CH)) begin
                w_scan = w_scan - 3'(NUM_CH);
            end
            if (!w_sel_vld && w_elig[w_scan[1:0]]) begin
                w_sel_vld             = 1'b1;
                w_sel_idx             = w_scan[1:0];
                w_sel_oh[w_scan[1:0]] = 1'b1;
            end
        end
    end

    // Next-state logic and the start/release/abort strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_release   = 1'b0;
        w_timeout   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (enable_i && c2d_hs_rdy_i && w_sel_vld) begin
                    w_start     = 1'b1;
                    w_state_nxt = StXfer;
                end
            end
            StXfer: begin
                // A done pulse coinciding with the watchdog limit is a clean finish.
                if (w_done || w_wd_hit) begin
                    w_release   = 1'b1;
                    w_timeout   = !w_done;
                    w_state_nxt = GAP_EN ? StGap : StIdle;
                end
            end
            StGap: begin
                if (r_gap_cnt == 8'd0) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge tx_clk_i) begin
        if (reset_tx_i) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Watchdog and gap counters.
    always_ff @(posedge tx_clk_i) begin
        if (reset_tx_i) begin
            r_wd_cnt  <= '0;
            r_gap_cnt <= '0;
        end else begin
            if (w_start) begin
                r_wd_cnt <= '0;
            end else if (r_state == StXfer && r_wd_cnt != 16'hFFFF) begin
                r_wd_cnt <= r_wd_cnt + 16'd1;
            end
            if (w_release) begin
                r_gap_cnt <= GAP_LOAD;
            end else if (r_state == StGap && r_gap_cnt != 8'd0) begin
                r_gap_cnt <= r_gap_cnt - 8'd1;
            end
        end
    end

    // Round-robin pointer moves past the channel just served.
    always_ff @(posedge tx_clk_i) begin
        if (reset_tx_i) begin
            r_rr_ptr <= '0;
        end else if (w_release) begin
            r_rr_ptr <= w_rr_nxt;
        end
    end

    // Registered grant, header latch and status outputs.
    always_ff @(posedge tx_clk_i) begin
        if (reset_tx_i) begin
            r_gnt       <= '0;
            r_pkt_req   <= 1'b0;
            r_pkt_wdcnt <= '0;
            r_pkt_dtype <= '0;
            r_pkt_vc    <= '0;
            r_pkt_sp    <= 1'b0;
            r_rdy       <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_rdy <= (w_state_nxt == StIdle) && enable_i;
            r_err <= w_timeout;
            if (w_start) begin
                r_gnt       <= w_sel_oh;
                r_pkt_req   <= 1'b1;
                r_pkt_wdcnt <= hdr_wdcnt_i[16*w_sel_idx +: 16];
                r_pkt_dtype <= hdr_dtype_i[6*w_sel_idx +: 6];
                r_pkt_vc    <= w_sel_idx;
                r_pkt_sp    <= hdr_sptype_i[w_sel_idx];
            end else if (w_release) begin
                // Data fields keep their last value; pkt_req_o qualifies them.
                r_gnt     <= '0;
                r_pkt_req <= 1'b0;
            end
        end
    end

    assign arb_rdy_o     = r_rdy;
    assign arb_gnt_o     = r_gnt;
    assign pkt_req_o     = r_pkt_req;
    assign pkt_wdcnt_o   = r_pkt_wdcnt;
    assign pkt_dtype_o   = r_pkt_dtype;
    assign pkt_vc_o      = r_pkt_vc;
    assign pkt_sp_o      = r_pkt_sp;
    assign busy_o        = (r_state != StIdle);
    assign err_timeout_o = r_err;

endmodule

// File: tb/tb_csi2_hdr_arbiter.sv
// Directed self-checking bench for csi2_hdr_arbiter (NUM_CH=4, MIN_GAP=2, TIMEOUT=16).
module tb_csi2_hdr_arbiter;

    localparam int unsigned NUM_CH  = 4;
    localparam int unsigned MIN_GAP = 2;
    localparam int unsigned TIMEOUT = 16;

    logic        tx_clk_i = 1'b0;
    logic        reset_tx_i;
    logic        enable_i;
    logic [3:0]  ch_mask_i;
    logic [3:0]  hdr_req_i;
    logic [63:0] hdr_wdcnt_i;
    logic [23:0] hdr_dtype_i;
    logic [3:0]  hdr_sptype_i;
    logic [3:0]  hdr_xfrdone_i;
    logic        c2d_hs_rdy_i;
    logic        arb_rdy_o;
    logic [3:0]  arb_gnt_o;
    logic        pkt_req_o;
    logic [15:0] pkt_wdcnt_o;
    logic [5:0]  pkt_dtype_o;
    logic [1:0]  pkt_vc_o;
    logic        pkt_sp_o;
    logic        busy_o;
    logic        err_timeout_o;

    int n_total = 0;
    int n_bad   = 0;

    always #5 tx_clk_i = ~tx_clk_i;

    csi2_hdr_arbiter #(
        .NUM_CH  (NUM_CH),
        .MIN_GAP (MIN_GAP),
        .TIMEOUT (TIMEOUT)
    ) u_dut (
        .tx_clk_i      (tx_clk_i),
        .reset_tx_i    (reset_tx_i),
        .enable_i      (enable_i),
        .ch_mask_i     (ch_mask_i),
        .hdr_req_i     (hdr_req_i),
        .hdr_wdcnt_i   (hdr_wdcnt_i),
        .hdr_dtype_i   (hdr_dtype_i),
        .hdr_sptype_i  (hdr_sptype_i),
        .hdr_xfrdone_i (hdr_xfrdone_i),
        .c2d_hs_rdy_i  (c2d_hs_rdy_i),
        .arb_rdy_o     (arb_rdy_o),
        .arb_gnt_o     (arb_gnt_o),
        .pkt_req_o     (pkt_req_o),
        .pkt_wdcnt_o   (pkt_wdcnt_o),
        .pkt_dtype_o   (pkt_dtype_o),
        .pkt_vc_o      (pkt_vc_o),
        .pkt_sp_o      (pkt_sp_o),
        .busy_o        (busy_o),
        .err_timeout_o (err_timeout_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and sample just after the edge.
    task automatic tick();
        @(posedge tx_clk_i);
        #1;
    endtask

    task automatic set_hdr(input int ch, input logic [15:0] wd, input logic [5:0] dt,
                           input logic sp);
        hdr_wdcnt_i[16*ch +: 16] = wd;
        hdr_dtype_i[6*ch +: 6]   = dt;
        hdr_sptype_i[ch]         = sp;
    endtask

    // Bounded wait for any grant, then check it is the expected channel.
    task automatic wait_grant(input int ch, input string tag);
        for (int i = 0; i < 20; i++) begin
            if (arb_gnt_o != 4'd0) break;
            tick();
        end
        check({tag, "_gnt"}, 32'(arb_gnt_o), 32'(1) << ch);
        check({tag, "_vc"}, 32'(pkt_vc_o), 32'(ch));
    endtask

    task automatic finish_pkt(input int ch, input string tag);
        tick();
        hdr_xfrdone_i[ch] = 1'b1;
        tick();
        hdr_xfrdone_i = '0;
        check({tag, "_rel"}, 32'(arb_gnt_o), 32'd0);
    endtask

    int e;
    int m_order[4] = '{3, 0, 1, 3};

    initial begin
        reset_tx_i    = 1'b1;
        enable_i      = 1'b1;
        ch_mask_i     = 4'hF;
        hdr_req_i     = '0;
        hdr_wdcnt_i   = '0;
        hdr_dtype_i   = '0;
        hdr_sptype_i  = '0;
        hdr_xfrdone_i = '0;
        c2d_hs_rdy_i  = 1'b1;
        tick();
        tick();
        check("rst_gnt", 32'(arb_gnt_o), 32'd0);
        check("rst_req", 32'(pkt_req_o), 32'd0);
        check("rst_rdy", 32'(arb_rdy_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_err", 32'(err_timeout_o), 32'd0);
        check("rst_wdcnt", 32'(pkt_wdcnt_o), 32'd0);
        reset_tx_i = 1'b0;
        tick();
        check("rdy_after_rst", 32'(arb_rdy_o), 32'd1);

        // Single packet on ch0, header latched, then MIN_GAP=2 gap.
        set_hdr(0, 16'h0500, 6'h2B, 1'b0);
        hdr_req_i = 4'b0001;
        tick();
        check("t1_gnt", 32'(arb_gnt_o), 32'h1);
        check("t1_req", 32'(pkt_req_o), 32'd1);
        check("t1_vc", 32'(pkt_vc_o), 32'd0);
        check("t1_wdcnt", 32'(pkt_wdcnt_o), 32'h0500);
        check("t1_dtype", 32'(pkt_dtype_o), 32'h2B);
        check("t1_sp", 32'(pkt_sp_o), 32'd0);
        check("t1_busy", 32'(busy_o), 32'd1);
        check("t1_rdy", 32'(arb_rdy_o), 32'd0);
        hdr_req_i = '0;
        set_hdr(0, 16'h1234, 6'h12, 1'b1);
        tick();
        check("t1_frozen_wd", 32'(pkt_wdcnt_o), 32'h0500);
        check("t1_hold_gnt", 32'(arb_gnt_o), 32'h1);
        hdr_xfrdone_i = 4'b0001;
        tick();
        hdr_xfrdone_i = '0;
        check("t1_rel_gnt", 32'(arb_gnt_o), 32'd0);
        check("t1_rel_req", 32'(pkt_req_o), 32'd0);
        check("t1_keep_wd", 32'(pkt_wdcnt_o), 32'h0500);
        check("t1_gap_busy", 32'(busy_o), 32'd1);
        check("t1_gap_rdy", 32'(arb_rdy_o), 32'd0);
        tick();
        check("t1_gap2_rdy", 32'(arb_rdy_o), 32'd0);
        tick();
        check("t1_idle_rdy", 32'(arb_rdy_o), 32'd1);
        check("t1_idle_busy", 32'(busy_o), 32'd0);

        // Round robin with all four requesting; pointer now at ch1.
        for (int c = 0; c < 4; c++) begin
            set_hdr(c, 16'(16'h0100 + c), 6'(6'h10 + c), 1'(c & 1));
        end
        hdr_req_i = 4'hF;
        tick();
        for (int k = 0; k < 6; k++) begin
            e = (1 + k) % 4;
            check($sformatf("rr%0d_gnt", k), 32'(arb_gnt_o), 32'(1) << e);
            check($sformatf("rr%0d_vc", k), 32'(pkt_vc_o), 32'(e));
            check($sformatf("rr%0d_wd", k), 32'(pkt_wdcnt_o), 32'(16'h0100 + e));
            check($sformatf("rr%0d_dt", k), 32'(pkt_dtype_o), 32'(6'h10 + e));
            check($sformatf("rr%0d_sp", k), 32'(pkt_sp_o), 32'(e & 1));
            repeat (9) tick();
            check($sformatf("rr%0d_hold", k), 32'(arb_gnt_o), 32'(1) << e);
            hdr_xfrdone_i[e] = 1'b1;
            tick();
            hdr_xfrdone_i = '0;
            check($sformatf("rr%0d_rel", k), 32'(arb_gnt_o), 32'd0);
            tick();
            tick();
            check($sformatf("rr%0d_gap", k), 32'(arb_gnt_o), 32'd0);
            if (k == 5) hdr_req_i = '0;
            tick();
        end
        check("rr_end_gnt", 32'(arb_gnt_o), 32'd0);

        // Masked channel 2 is skipped; pointer starts at ch3.
        ch_mask_i = 4'b1011;
        hdr_req_i = 4'hF;
        for (int k = 0; k < 4; k++) begin
            wait_grant(m_order[k], $sformatf("mask%0d", k));
            finish_pkt(m_order[k], $sformatf("mask%0d", k));
        end

        // Dropping enable mid-packet lets it finish but blocks new grants.
        wait_grant(0, "en");
        enable_i = 1'b0;
        finish_pkt(0, "en");
        repeat (10) tick();
        check("en_off_gnt", 32'(arb_gnt_o), 32'd0);
        check("en_off_rdy", 32'(arb_rdy_o), 32'd0);
        enable_i = 1'b1;
        wait_grant(1, "en_on");
        finish_pkt(1, "en_on");
        ch_mask_i = 4'hF;

        // Watchdog abort on ch1, then ch2 is served next.
        hdr_req_i = 4'b0010;
        wait_grant(1, "wd");
        hdr_req_i = 4'b0110;
        repeat (15) tick();
        check("wd_pre_err", 32'(err_timeout_o), 32'd0);
        check("wd_pre_gnt", 32'(arb_gnt_o), 32'h2);
        tick();
        check("wd_err", 32'(err_timeout_o), 32'd1);
        check("wd_drop_gnt", 32'(arb_gnt_o), 32'd0);
        check("wd_drop_req", 32'(pkt_req_o), 32'd0);
        tick();
        check("wd_err_once", 32'(err_timeout_o), 32'd0);
        tick();
        check("wd_gap_gnt", 32'(arb_gnt_o), 32'd0);
        tick();
        check("wd_next_gnt", 32'(arb_gnt_o), 32'h4);
        check("wd_next_vc", 32'(pkt_vc_o), 32'd2);
        finish_pkt(2, "wd_next");

        // Done arriving on the watchdog's last cycle wins.
        hdr_req_i = 4'b0010;
        wait_grant(1, "wd2");
        repeat (15) tick();
        hdr_xfrdone_i = 4'b0010;
        tick();
        hdr_xfrdone_i = '0;
        check("wd2_err", 32'(err_timeout_o), 32'd0);
        check("wd2_gnt", 32'(arb_gnt_o), 32'd0);
        tick();
        check("wd2_err_late", 32'(err_timeout_o), 32'd0);

        // Foreign done, request drop and mask change do not disturb the grant.
        wait_grant(1, "ig");
        hdr_xfrdone_i = 4'b0100;
        tick();
        hdr_xfrdone_i = '0;
        check("ig_hold", 32'(arb_gnt_o), 32'h2);
        hdr_req_i = '0;
        ch_mask_i = '0;
        set_hdr(1, 16'hBEEF, 6'h3F, 1'b0);
        tick();
        check("ig_hold2", 32'(arb_gnt_o), 32'h2);
        check("ig_wd", 32'(pkt_wdcnt_o), 32'h0101);
        ch_mask_i = 4'hF;
        finish_pkt(1, "ig");

        // No grant while the PHY is not ready.
        c2d_hs_rdy_i = 1'b0;
        hdr_req_i    = 4'hF;
        repeat (8) tick();
        check("hs_gnt_off", 32'(arb_gnt_o), 32'd0);
        c2d_hs_rdy_i = 1'b1;
        tick();
        check("hs_gnt_on", 32'(arb_gnt_o), 32'h4);

        // Reset mid-transfer clears everything and the pointer.
        reset_tx_i = 1'b1;
        tick();
        check("mrst_gnt", 32'(arb_gnt_o), 32'd0);
        check("mrst_req", 32'(pkt_req_o), 32'd0);
        check("mrst_vc", 32'(pkt_vc_o), 32'd0);
        check("mrst_wd", 32'(pkt_wdcnt_o), 32'd0);
        check("mrst_dt", 32'(pkt_dtype_o), 32'd0);
        check("mrst_sp", 32'(pkt_sp_o), 32'd0);
        check("mrst_busy", 32'(busy_o), 32'd0);
        check("mrst_rdy", 32'(arb_rdy_o), 32'd0);
        reset_tx_i = 1'b0;
        tick();
        check("mrst_first_gnt", 32'(arb_gnt_o), 32'h1);
        check("mrst_first_vc", 32'(pkt_vc_o), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
